// File: rtl/dcache_flush_walker.sv
// Whole-D$ write-back-and-invalidate sequencer for FENCE / FENCE.I.
// Walks every set, writes back valid+dirty ways lowest-first, invalidates the set, then acks once.
module dcache_flush_walker #(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 8,
  parameter int SET_W    = $clog2(NUM_SETS),
  parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  output logic                flush_ack_o,
  output logic                busy_o,
  output logic                tag_req_o,
  output logic [SET_W-1:0]    tag_set_o,
  input  logic                tag_gnt_i,
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [NUM_WAYS-1:0] dirty_i,
  output logic                wb_req_o,
  output logic [SET_W-1:0]    wb_set_o,
  output logic [WAY_W-1:0]    wb_way_o,
  input  logic                wb_gnt_i,
  input  logic                wb_done_i,
  output logic                inv_o,
  output logic [SET_W-1:0]    inv_set_o,
  output logic [15:0]         wb_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_RSP, S_WB, S_WB_WAIT, S_INVAL, S_ACK, S_REARM
  } state_e;

  state_e              state_q, state_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic [NUM_WAYS-1:0] mask_q, mask_d;
  logic [15:0]         cnt_q, cnt_d;

  logic [WAY_W-1:0]    way_sel;
  logic [NUM_WAYS-1:0] way_oh;
  logic [NUM_WAYS-1:0] rsp_mask;

  assign rsp_mask = valid_i & dirty_i;

  // Lowest pending way; scanning downward lets the lowest index win.
  always_comb begin
    way_sel = '0;
    way_oh  = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        way_sel   = WAY_W'(i);
        way_oh    = '0;
        way_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d = S_READ;
          set_d   = '0;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        if (tag_gnt_i) state_d = S_RSP;
      end
      S_RSP: begin
        mask_d  = rsp_mask;
        state_d = (|rsp_mask) ? S_WB : S_INVAL;
      end
      S_WB: begin
        if (wb_gnt_i) state_d = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        if (wb_done_i) begin
          mask_d  = mask_q & ~way_oh;
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          state_d = (|(mask_q & ~way_oh)) ? S_WB : S_INVAL;
        end
      end
      S_INVAL: begin
        if (set_q == SET_W'(NUM_SETS - 1)) begin
          state_d = S_ACK;
        end else begin
          set_d   = set_q + SET_W'(1);
          state_d = S_READ;
        end
      end
      S_ACK:   state_d = S_REARM;
      // The request level lingers one cycle past the ack; don't re-trigger on it.
      S_REARM: if (!flush_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign tag_req_o   = (state_q == S_READ);
  assign tag_set_o   = set_q;
  assign wb_req_o    = (state_q == S_WB);
  assign wb_set_o    = set_q;
  assign wb_way_o    = way_sel;
  assign inv_o       = (state_q == S_INVAL);
  assign inv_set_o   = set_q;
  assign flush_ack_o = (state_q == S_ACK);
  assign wb_count_o  = cnt_q;

endmodule

// File: tb/tb_dcache_flush_walker.sv
// Scoreboard bench for dcache_flush_walker: stimulus pushes expected events, a monitor pops and compares.
module tb_dcache_flush_walker;
  localparam int NS = 4;
  localparam int NW = 2;
  localparam int SW = 2;
  localparam int WW = 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          tag_gnt_i, wb_gnt_i, wb_done_i;
  logic [NW-1:0] valid_i, dirty_i;
  logic          flush_ack_o, busy_o, tag_req_o, wb_req_o, inv_o;
  logic [SW-1:0] tag_set_o, wb_set_o, inv_set_o;
  logic [WW-1:0] wb_way_o;
  logic [15:0]   wb_count_o;

  dcache_flush_walker #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_ack_o(flush_ack_o),
    .busy_o(busy_o), .tag_req_o(tag_req_o), .tag_set_o(tag_set_o), .tag_gnt_i(tag_gnt_i),
    .valid_i(valid_i), .dirty_i(dirty_i), .wb_req_o(wb_req_o), .wb_set_o(wb_set_o),
    .wb_way_o(wb_way_o), .wb_gnt_i(wb_gnt_i), .wb_done_i(wb_done_i), .inv_o(inv_o),
    .inv_set_o(inv_set_o), .wb_count_o(wb_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int kind;  // 0 inval, 1 write-back accepted, 2 ack
    int set;
    int way;
    int cyc;   // -1 = any cycle
    int cnt;
  } ev_t;

  ev_t q[$];
  int nchk = 0, nerr = 0;
  int cyc = 0, t0 = 0;

  logic [NW-1:0] vcfg [NS];
  logic [NW-1:0] dcfg [NS];
  assign valid_i = vcfg[tag_set_o];
  assign dirty_i = dcfg[tag_set_o];

  int tag_stall_set = -1, tag_stall = 0, tcnt = 0;
  int wb_stall = 0, wcnt = 0, done_dly = 1, dcnt = -1;
  bit spurious = 0;

  task automatic push(int k, int s, int w, int c, int n);
    ev_t e;
    e.kind = k; e.set = s; e.way = w; e.cyc = c; e.cnt = n;
    q.push_back(e);
  endtask

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_ev(int k, int s, int w, int c, int n);
    ev_t e;
    nchk++;
    if (q.size() == 0) begin
      nerr++;
      $display("FAIL unexpected_event: got kind=%0d set=%0d way=%0d cyc=%0d cnt=%0d expected none",
               k, s, w, c, n);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.set != s || e.way != w || (e.cyc != -1 && e.cyc != c) || e.cnt != n) begin
        nerr++;
        $display("FAIL event: got kind=%0d set=%0d way=%0d cyc=%0d cnt=%0d expected kind=%0d set=%0d way=%0d cyc=%0d cnt=%0d",
                 k, s, w, c, n, e.kind, e.set, e.way, e.cyc, e.cnt);
      end
    end
  endtask

  // Memory-side responder: grants with optional stalls, write-back done after done_dly cycles.
  initial begin
    tag_gnt_i = 1'b1; wb_gnt_i = 1'b1; wb_done_i = 1'b0;
    forever begin
      @(negedge clk_i);
      wb_done_i = 1'b0;
      if (dcnt > 0) dcnt--;
      if (dcnt == 0) begin wb_done_i = 1'b1; dcnt = -1; end
      if (spurious && (tag_req_o || inv_o)) wb_done_i = 1'b1;
      tag_gnt_i = 1'b1;
      if (tag_req_o && int'(tag_set_o) == tag_stall_set && tcnt < tag_stall) begin
        tag_gnt_i = 1'b0; tcnt++;
      end
      wb_gnt_i = 1'b1;
      if (wb_req_o && wcnt < wb_stall) begin wb_gnt_i = 1'b0; wcnt++; end
      if (wb_req_o && wb_gnt_i) dcnt = done_dly;
    end
  end

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Monitor: event capture plus hold-stability of stalled requests.
  bit p_ok = 0, p_treq = 0, p_tgnt = 0, p_wreq = 0, p_wgnt = 0;
  logic [SW-1:0] p_tset, p_wset;
  logic [WW-1:0] p_way;
  initial forever begin
    @(negedge clk_i);
    #1;
    if (rst_ni) begin
      if (inv_o) check_ev(0, int'(inv_set_o), 0, cyc - t0 + 1, 0);
      if (wb_req_o && wb_gnt_i) check_ev(1, int'(wb_set_o), int'(wb_way_o), cyc - t0 + 1, 0);
      if (flush_ack_o) check_ev(2, 0, 0, cyc - t0 + 1, int'(wb_count_o));
      if (p_ok && p_treq && !p_tgnt)
        chk("tag_req_hold", int'({tag_req_o, tag_set_o}), int'({1'b1, p_tset}));
      if (p_ok && p_wreq && !p_wgnt)
        chk("wb_req_hold", int'({wb_req_o, wb_set_o, wb_way_o}), int'({1'b1, p_wset, p_way}));
    end
    p_ok = rst_ni; p_treq = tag_req_o; p_tgnt = tag_gnt_i; p_tset = tag_set_o;
    p_wreq = wb_req_o; p_wgnt = wb_gnt_i; p_wset = wb_set_o; p_way = wb_way_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_zero(string tag);
    chk({tag, "_ack"}, int'(flush_ack_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_reqs"}, int'({tag_req_o, wb_req_o, inv_o}), 0);
    chk({tag, "_idx"}, int'({tag_set_o, wb_set_o, wb_way_o, inv_set_o}), 0);
    chk({tag, "_count"}, int'(wb_count_o), 0);
  endtask

  task automatic set_cfg(logic [NW-1:0] v2, logic [NW-1:0] d2, int set_idx);
    for (int i = 0; i < NS; i++) begin vcfg[i] = '0; dcfg[i] = '0; end
    vcfg[set_idx] = v2; dcfg[set_idx] = d2;
    tcnt = 0; wcnt = 0;
  endtask

  // Call at a negedge while the DUT is idle; returns in cycle 1 of the walk.
  task automatic start_walk();
    flush_i = 1'b1;
    t0 = cyc + 1;
    @(negedge clk_i);
    chk("busy_cycle1", int'(busy_o), 1);
    chk("count_cleared", int'(wb_count_o), 0);
  endtask

  task automatic wait_ack(int lim);
    bit seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk_i);
      #2;
      if (flush_ack_o) seen = 1;
    end
    chk("ack_seen", int'(seen), 1);
  endtask

  task automatic finish_walk();
    wait_ack(300);
    flush_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("idle_busy", int'(busy_o), 0);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic push_clean();
    for (int s = 0; s < NS; s++) push(0, s, 0, 3 + 3 * s, 0);
    push(2, 0, 0, 3 * NS + 1, 0);
  endtask

  task automatic push_dirty_set2();
    push(0, 0, 0, 3, 0);
    push(0, 1, 0, 6, 0);
    push(1, 2, 1, 9, 0);
    push(0, 2, 0, 14, 0);
    push(0, 3, 0, 17, 0);
    push(2, 0, 0, 18, 1);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin vcfg[i] = '0; dcfg[i] = '0; end
    repeat (3) @(negedge clk_i);
    check_zero("reset");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // 1: clean walk, all grants high
    set_cfg(2'b00, 2'b00, 0);
    push_clean();
    start_walk();
    finish_walk();

    // 2: set 2 has one dirty way (way 1), done 4 cycles after the grant
    set_cfg(2'b11, 2'b10, 2);
    done_dly = 4;
    push_dirty_set2();
    start_walk();
    finish_walk();

    // 3: tag grant stalled 7 cycles on set 1, write-back grant stalled 3 cycles
    set_cfg(2'b01, 2'b01, 1);
    tag_stall_set = 1; tag_stall = 7; wb_stall = 3; done_dly = 1;
    push(0, 0, 0, 3, 0);
    push(1, 1, 0, 16, 0);
    push(0, 1, 0, 18, 0);
    push(0, 2, 0, 21, 0);
    push(0, 3, 0, 24, 0);
    push(2, 0, 0, 25, 1);
    start_walk();
    finish_walk();
    tag_stall_set = -1; tag_stall = 0; wb_stall = 0;

    // 4: request held one cycle past the ack, then re-raised; count must restart
    set_cfg(2'b11, 2'b10, 2);
    done_dly = 4;
    push_dirty_set2();
    start_walk();
    wait_ack(300);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rearm_idle", int'(busy_o), 0);
    chk("single_ack_queue", q.size(), 0);
    push_dirty_set2();
    start_walk();
    finish_walk();

    // 5: reset during WB_WAIT of set 1
    set_cfg(2'b01, 2'b01, 1);
    done_dly = 10;
    push(0, 0, 0, 3, 0);
    push(1, 1, 0, 6, 0);
    start_walk();
    while (cyc - t0 + 1 < 9) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    dcnt = -1;
    #1;
    check_zero("midreset");
    repeat (3) @(negedge clk_i);
    chk("reset_queue", q.size(), 0);
    chk("reset_no_ack", int'(flush_ack_o), 0);
    flush_i = 1'b0;
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    set_cfg(2'b00, 2'b00, 0);
    push_clean();
    start_walk();
    finish_walk();

    // 6: spurious dones in READ/INVAL, dirty-but-invalid lines everywhere
    for (int i = 0; i < NS; i++) begin vcfg[i] = 2'b00; dcfg[i] = 2'b11; end
    tcnt = 0; wcnt = 0;
    spurious = 1;
    push_clean();
    start_walk();
    finish_walk();
    spurious = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
